kl_alu_muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer that drives an external W-bit ALU built from cascaded 4-bit mc10181 slices.
- Owns the accumulator (AR), multiplier/quotient (MQ) and operand (BR) registers.
- Issues one ALU function code per clock and shifts the ALU result back into AR/MQ.
- Sits between the execute control logic and the shared ALU datapath; the ALU itself is combinational and external.

---
 rtl/kl_alu_muldiv_seq.sv | 157 +++++++++++++++
 tb/tb_kl_alu_muldiv_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/kl_alu_muldiv_seq.sv
// kl_alu_muldiv_seq
//   Iterative unsigned multiply / restoring divide sequencer. Owns AR
//   (accumulator / partial remainder), MQ (multiplier / quotient) and BR
//   (multiplicand / divisor). Each RUN cycle it issues one function code to
//   an external combinational ALU (cascaded 4-bit mc10181 slices) and
//   shifts the result back into AR/MQ. One step per clock, W steps per op.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start, op, abort  command: op 0 = multiply, 1 = divide
//   opa, opb          multiplier/dividend, multiplicand/divisor
//   busy, done, dz    status: RUN, one-cycle completion, divide-by-zero
//   res_hi, res_lo    product hi/lo, or remainder/quotient
//   alu_s, alu_m, alu_cin, alu_a, alu_b   ALU controls and operands
//   alu_f, alu_cout   ALU result and carry out of bit W-1
//   dbg_state         current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is accepted on any clock edge where the sequencer is
// not in RUN (start while in RUN is ignored). Acceptance is not
// acknowledged separately; busy rises on the following cycle unless the
// op is a divide by zero, in which case done rises instead. done is a
// single-cycle pulse and results stay valid until the next accepted start.
module kl_alu_muldiv_seq #(
  parameter int W  = 36,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic         abort,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_cin,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_f,
  input  logic         alu_cout,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [W-1:0]  ar, mq, br;
  logic [W-1:0]  ar_nx, mq_nx, sh;
  logic [CW-1:0] cnt;
  logic          op_r;
  logic          q;
  logic          accept;
  logic          div_zero;

  assign accept    = start && (state != S_RUN);
  assign div_zero  = op && (opb == '0);
  assign alu_m     = 1'b0;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    alu_s    = 4'b0000;
    alu_cin  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    ar_nx    = ar;
    mq_nx    = mq;
    sh       = {ar[W-2:0], mq[W-1]};
    q        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = div_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        alu_b = br;
        if (!op_r) begin
          // Add-and-shift: ALU carry becomes the new top bit of AR.
          alu_a = ar;
          if (mq[0]) alu_s = 4'b0110;
          ar_nx = {alu_cout, alu_f[W-1:1]};
          mq_nx = {alu_f[0], mq[W-1:1]};
        end else begin
          // Shift-and-subtract. The bit shifted out of AR[W-1] is the
          // (W+1)th bit of the partial remainder; when set the trial
          // subtraction always succeeds even if the ALU reports a borrow.
          alu_a   = sh;
          alu_s   = 4'b1001;
          alu_cin = 1'b1;
          q       = ar[W-1] | alu_cout;
          ar_nx   = q ? alu_f : sh;
          mq_nx   = {mq[W-2:0], q};
        end
        if (abort)                  state_nx = S_IDLE;
        else if (cnt == CW'(1))     state_nx = S_DONE;
      end
      S_DONE: begin
        if (start) state_nx = div_zero ? S_DONE : S_RUN;
        else       state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ar     <= '0;
      mq     <= '0;
      br     <= '0;
      cnt    <= '0;
      op_r   <= 1'b0;
      dz     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == S_RUN);
      done  <= (state_nx == S_DONE);
      if (accept) begin
        br   <= opb;
        mq   <= opa;
        ar   <= '0;
        cnt  <= CW'(W);
        op_r <= op;
        if (div_zero) begin
          dz     <= 1'b1;
          res_hi <= opa;
          res_lo <= '1;
        end else begin
          dz <= 1'b0;
        end
      end else if (state == S_RUN && !abort) begin
        ar  <= ar_nx;
        mq  <= mq_nx;
        cnt <= cnt - CW'(1);
        // Results are published only on normal completion, so an aborted
        // op leaves the previous results visible.
        if (cnt == CW'(1)) begin
          res_hi <= ar_nx;
          res_lo <= mq_nx;
        end
      end
    end
  end

endmodule

// File: tb/tb_kl_alu_muldiv_seq.sv
// Bench for kl_alu_muldiv_seq: a W=8 instance for directed vectors and a
// W=36 instance for a randomized regression, each driving a ripple chain of
// 4-bit mc10181-style slices.
module tb_kl_alu_muldiv_seq;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- W = 8 instance ----------------
  logic        rst8, start8, op8, abort8;
  logic [7:0]  opa8, opb8, res_hi8, res_lo8, alu_a8, alu_b8, alu_f8;
  logic        busy8, done8, dz8, alu_m8, alu_cin8, alu_cout8;
  logic [3:0]  alu_s8;
  logic [1:0]  dbg8;
  logic [36:0] alu_r8;

  kl_alu_muldiv_seq #(.W(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .op(op8), .abort(abort8),
    .opa(opa8), .opb(opb8), .busy(busy8), .done(done8), .dz(dz8),
    .res_hi(res_hi8), .res_lo(res_lo8), .alu_s(alu_s8), .alu_m(alu_m8),
    .alu_cin(alu_cin8), .alu_a(alu_a8), .alu_b(alu_b8), .alu_f(alu_f8),
    .alu_cout(alu_cout8), .dbg_state(dbg8)
  );

  // ---------------- W = 36 instance ----------------
  logic        rst36, start36, op36, abort36;
  logic [35:0] opa36, opb36, res_hi36, res_lo36, alu_a36, alu_b36, alu_f36;
  logic        busy36, done36, dz36, alu_m36, alu_cin36, alu_cout36;
  logic [3:0]  alu_s36;
  logic [1:0]  dbg36;
  logic [36:0] alu_r36;

  kl_alu_muldiv_seq #(.W(36)) u36 (
    .clk(clk), .reset(rst36), .start(start36), .op(op36), .abort(abort36),
    .opa(opa36), .opb(opb36), .busy(busy36), .done(done36), .dz(dz36),
    .res_hi(res_hi36), .res_lo(res_lo36), .alu_s(alu_s36), .alu_m(alu_m36),
    .alu_cin(alu_cin36), .alu_a(alu_a36), .alu_b(alu_b36), .alu_f(alu_f36),
    .alu_cout(alu_cout36), .dbg_state(dbg36)
  );

  // Ripple chain of 4-bit slices (arithmetic mode). Returns {cout, f}.
  function automatic logic [36:0] alu_chain(input logic [3:0] s, input logic cin,
                                            input logic [35:0] a, input logic [35:0] b,
                                            input int nsl);
    logic        c;
    logic [35:0] f;
    logic [3:0]  na, nb;
    logic [4:0]  r;
    c = cin;
    f = '0;
    for (int i = 0; i < nsl; i++) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      case (s)
        4'b0000: r = {1'b0, na} + {4'b0, c};
        4'b0110: r = {1'b0, na} + {1'b0, nb} + {4'b0, c};
        4'b1001: r = {1'b0, na} + {1'b0, ~nb} + {4'b0, c};
        default: r = 5'b0;
      endcase
      f[4*i +: 4] = r[3:0];
      c = r[4];
    end
    return {c, f};
  endfunction

  always_comb begin
    alu_r8    = alu_chain(alu_s8, alu_cin8, {28'b0, alu_a8}, {28'b0, alu_b8}, 2);
    alu_f8    = alu_r8[7:0];
    alu_cout8 = alu_r8[36];
  end

  always_comb begin
    alu_r36    = alu_chain(alu_s36, alu_cin36, alu_a36, alu_b36, 9);
    alu_f36    = alu_r36[35:0];
    alu_cout36 = alu_r36[36];
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one W=8 op from IDLE and check latency, results and the done pulse.
  task automatic run8(input string tag, input logic op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] e_hi,
                      input logic [7:0] e_lo, input logic e_dz, input int e_lat);
    int   n;
    logic saw_busy;
    op8 = op; opa8 = a; opb8 = b; start8 = 1'b1;
    @(negedge clk);
    start8   = 1'b0;
    n        = 1;
    saw_busy = busy8;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
      saw_busy = saw_busy | busy8;
    end
    check({tag, "_lat"},  72'(n),       72'(e_lat));
    check({tag, "_done"}, 72'(done8),   72'd1);
    check({tag, "_busy"}, 72'(saw_busy), 72'(!e_dz));
    check({tag, "_hi"},   72'(res_hi8), 72'(e_hi));
    check({tag, "_lo"},   72'(res_lo8), 72'(e_lo));
    check({tag, "_dz"},   72'(dz8),     72'(e_dz));
    @(negedge clk);
    check({tag, "_pulse"}, 72'({done8, busy8}), 72'd0);
    check({tag, "_hold"},  72'({res_hi8, res_lo8}), 72'({e_hi, e_lo}));
  endtask

  initial begin
    logic [35:0] a, b, e_hi, e_lo;
    logic [71:0] prod;
    logic        op, e_dz, saw_done;
    int          n, e_lat;

    rst8 = 1'b1; start8 = 1'b0; op8 = 1'b0; abort8 = 1'b0; opa8 = '0; opb8 = '0;
    rst36 = 1'b1; start36 = 1'b0; op36 = 1'b0; abort36 = 1'b0; opa36 = '0; opb36 = '0;
    repeat (3) @(negedge clk);
    check("rst8_out", 72'({busy8, done8, dz8, res_hi8, res_lo8, alu_s8, alu_m8,
                           alu_cin8, alu_a8, alu_b8, dbg8}), 72'd0);
    check("rst36_out", 72'({busy36, done36, dz36, alu_s36, alu_m36, alu_cin36, dbg36}), 72'd0);
    check("rst36_res", {res_hi36, res_lo36}, 72'd0);
    rst8 = 1'b0; rst36 = 1'b0;
    @(negedge clk);

    // Directed W=8 vectors.
    run8("mul_ff_ff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 9);
    run8("div_200_7", 1'b1, 8'd200, 8'd7, 8'd4, 8'd28, 1'b0, 9);
    run8("div_by_0",  1'b1, 8'h80, 8'h00, 8'h80, 8'hFF, 1'b1, 1);
    run8("div_ff_81", 1'b1, 8'hFF, 8'h81, 8'h7E, 8'h01, 1'b0, 9);

    // Abort on the third step of a multiply: no done, previous results kept.
    op8 = 1'b0; opa8 = 8'h12; opb8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_pre", 72'(busy8), 72'd1);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    check("abort_idle", 72'({busy8, done8, dbg8}), 72'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_done = saw_done | done8 | busy8;
    end
    check("abort_no_done", 72'(saw_done), 72'd0);
    check("abort_res_kept", 72'({res_hi8, res_lo8}), 72'h7E01);
    run8("mul_3_5", 1'b0, 8'd3, 8'd5, 8'd0, 8'd15, 1'b0, 9);

    // W=36 regression against an arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      if (i == 500) begin
        op36 = 1'b0; opa36 = 36'hF_FFFF_FFFF; opb36 = 36'h1_2345_6789; start36 = 1'b1;
        @(negedge clk);
        start36 = 1'b0;
        repeat (10) @(negedge clk);
        rst36 = 1'b1;
        @(negedge clk);
        rst36 = 1'b0;
        check("midrun_rst_ctl", 72'({busy36, done36, dz36, alu_s36, alu_m36, alu_cin36, dbg36}), 72'd0);
        check("midrun_rst_res", {res_hi36, res_lo36}, 72'd0);
        check("midrun_rst_alu", {alu_a36, alu_b36}, 72'd0);
        @(negedge clk);
      end
      op = 1'($urandom_range(0, 1));
      a  = {4'($urandom_range(0, 15)), 32'($urandom())};
      b  = {4'($urandom_range(0, 15)), 32'($urandom())};
      a  = a >> $urandom_range(0, 35);
      b  = b >> $urandom_range(0, 35);
      if (op && $urandom_range(0, 15) == 0) b = '0;
      if (!op) begin
        prod  = {36'b0, a} * {36'b0, b};
        e_hi  = prod[71:36];
        e_lo  = prod[35:0];
        e_dz  = 1'b0;
        e_lat = 37;
      end else if (b == '0) begin
        e_hi  = a;
        e_lo  = '1;
        e_dz  = 1'b1;
        e_lat = 1;
      end else begin
        e_hi  = a % b;
        e_lo  = a / b;
        e_dz  = 1'b0;
        e_lat = 37;
      end
      // Entered either from IDLE or directly in the DONE cycle of the last op.
      op36 = op; opa36 = a; opb36 = b; start36 = 1'b1;
      @(negedge clk);
      start36 = 1'b0;
      n = 1;
      while (!done36 && n < 60) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("r%0d_lat", i), 72'(n), 72'(e_lat));
      check($sformatf("r%0d_res", i), {res_hi36, res_lo36}, {e_hi, e_lo});
      check($sformatf("r%0d_dz", i), 72'({done36, dz36}), 72'({1'b1, e_dz}));
      if ($urandom_range(0, 3) != 0) begin
        @(negedge clk);
        check($sformatf("r%0d_pulse", i), 72'({done36, busy36}), 72'd0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
